elastic_pipe_buffer: RTL and testbench



---
 rtl/elastic_pipe_buffer_if.sv | 32 +++
 rtl/elastic_pipe_buffer.sv | 67 ++++++
 tb/tb_elastic_pipe_buffer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/elastic_pipe_buffer_if.sv
// Handshake bundle between a producer stage, the elastic buffer and a consumer stage.
// The slave modport is the buffer's view; master is the surrounding pipeline's view.
interface elastic_pipe_buffer_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/elastic_pipe_buffer.sv
// Elastic pipeline register: a DEPTH-entry circular queue with valid/ready on both
// sides, plus hazard-unit stall (freeze) and flush (squash) controls.
// Handshake outputs depend only on registered state and stall/flush, so there is no
// combinational path from out_ready to in_ready or from in_valid to out_valid.
module elastic_pipe_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         flush,
  elastic_pipe_buffer_if.slave         bus,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rdPtr;
  logic [PW-1:0]    wrPtr;
  logic             push;
  logic             pop;

  // Pointers wrap explicitly because DEPTH need not be a power of two.
  function automatic logic [PW-1:0] advance(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else                     return p + 1'b1;
  endfunction

  // Handshake and status decode from registered occupancy and hazard controls.
  always_comb begin
    bus.in_ready  = ~stall & ~flush & (count != CW'(DEPTH));
    bus.out_valid = ~stall & ~flush & (count != '0);
    bus.out_data  = bus.out_valid ? mem[rdPtr] : '0;
    full          = (count == CW'(DEPTH));
    empty         = (count == '0);
    push          = bus.in_valid & bus.in_ready;
    pop           = bus.out_valid & bus.out_ready;
  end

  // Pointer and occupancy bookkeeping; reset beats flush, and both discard any transfer.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
    end else begin
      if (push) wrPtr <= advance(wrPtr);
      if (pop)  rdPtr <= advance(rdPtr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents are not cleared since count gates visibility.
  always_ff @(posedge clk) begin
    if (!reset && push) mem[wrPtr] <= bus.in_data;
  end

endmodule

// File: tb/tb_elastic_pipe_buffer.sv
// Bench for elastic_pipe_buffer: a DEPTH=3 and a DEPTH=1 instance driven with identical
// stimulus, each checked every cycle against a queue-based model of the buffer.
module tb_elastic_pipe_buffer;

  logic clk = 1'b0;
  logic reset, stall, flush;
  logic [1:0] countA;
  logic [0:0] countB;
  logic fullA, emptyA, fullB, emptyB;

  int vectors = 0;
  int miscompares = 0;
  int pushesB = 0;

  logic [7:0] qA[$];
  logic [7:0] qB[$];

  elastic_pipe_buffer_if #(.WIDTH(8)) ifA ();
  elastic_pipe_buffer_if #(.WIDTH(8)) ifB ();

  elastic_pipe_buffer #(.WIDTH(8), .DEPTH(3)) dutA (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .bus(ifA.slave), .count(countA), .full(fullA), .empty(emptyA)
  );

  elastic_pipe_buffer #(.WIDTH(8), .DEPTH(1)) dutB (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .bus(ifB.slave), .count(countB), .full(fullB), .empty(emptyB)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model at the edge.
  task automatic step(input bit rst, input bit stl, input bit fl, input bit iv,
                      input logic [7:0] d, input bit ordy);
    bit rdyA, valA, rdyB, valB;
    reset = rst; stall = stl; flush = fl;
    ifA.in_valid = iv; ifA.in_data = d; ifA.out_ready = ordy;
    ifB.in_valid = iv; ifB.in_data = d; ifB.out_ready = ordy;
    #1;
    rdyA = !stl && !fl && (qA.size() < 3);
    valA = !stl && !fl && (qA.size() > 0);
    rdyB = !stl && !fl && (qB.size() < 1);
    valB = !stl && !fl && (qB.size() > 0);
    chk("A.in_ready",  ifA.in_ready,  rdyA);
    chk("A.out_valid", ifA.out_valid, valA);
    chk("A.out_data",  ifA.out_data,  valA ? qA[0] : 8'h00);
    chk("A.count",     countA,        qA.size());
    chk("A.full",      fullA,         qA.size() == 3);
    chk("A.empty",     emptyA,        qA.size() == 0);
    chk("B.in_ready",  ifB.in_ready,  rdyB);
    chk("B.out_valid", ifB.out_valid, valB);
    chk("B.out_data",  ifB.out_data,  valB ? qB[0] : 8'h00);
    chk("B.count",     countB,        qB.size());
    chk("B.full",      fullB,         qB.size() == 1);
    chk("B.empty",     emptyB,        qB.size() == 0);
    if (iv && ifB.in_ready) pushesB++;
    @(posedge clk);
    if (rst || fl) begin
      qA.delete();
      qB.delete();
    end else begin
      if (valA && ordy) void'(qA.pop_front());
      if (rdyA && iv)   qA.push_back(d);
      if (valB && ordy) void'(qB.pop_front());
      if (rdyB && iv)   qB.push_back(d);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    ifA.in_valid = 1'b0; ifA.in_data = '0; ifA.out_ready = 1'b0;
    ifB.in_valid = 1'b0; ifB.in_data = '0; ifB.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state.
    step(0, 0, 0, 0, 8'h00, 0);

    // Fill DEPTH=3 to full.
    step(0, 0, 0, 1, 8'h11, 0);
    step(0, 0, 0, 1, 8'h22, 0);
    step(0, 0, 0, 1, 8'h33, 0);
    #1;
    chk("A.fill.count", countA, 2'd3);
    chk("A.fill.full", fullA, 1'b1);
    chk("A.fill.in_ready", ifA.in_ready, 1'b0);
    chk("A.fill.head", ifA.out_data, 8'h11);
    #0;

    // Pop from full while offering 0x44; then drain (exercises pointer wrap).
    step(0, 0, 0, 1, 8'h44, 1);
    step(0, 0, 0, 1, 8'h44, 1);
    #1;
    chk("A.popfull.count", countA, 2'd2);
    step(0, 0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 0, 8'h00, 1);

    // Streaming 0x01..0x0A.
    for (int i = 1; i <= 10; i++) step(0, 0, 0, 1, 8'(i), 1);
    repeat (3) step(0, 0, 0, 0, 8'h00, 1);

    // Stall with two entries held.
    step(0, 0, 0, 1, 8'hA5, 0);
    step(0, 0, 0, 1, 8'h5A, 0);
    repeat (3) step(0, 1, 0, 1, 8'hEE, 1);
    #1;
    chk("A.stall.count", countA, 2'd2);
    step(0, 0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 0, 8'h00, 1);

    // Flush together with stall, then a fresh push.
    step(0, 0, 0, 1, 8'h01, 0);
    step(0, 0, 0, 1, 8'h02, 0);
    step(0, 0, 0, 1, 8'h03, 0);
    step(0, 1, 1, 1, 8'h04, 1);
    #1;
    chk("A.flush.empty", emptyA, 1'b1);
    step(0, 0, 0, 1, 8'h77, 0);
    #1;
    chk("A.flush.next", ifA.out_data, 8'h77);
    step(0, 0, 0, 0, 8'h00, 1);

    // Reset during a push with two entries held.
    step(0, 0, 0, 1, 8'h61, 0);
    step(0, 0, 0, 1, 8'h62, 0);
    step(1, 0, 0, 1, 8'h99, 1);
    #1;
    chk("A.reset.count", countA, 2'd0);
    chk("A.reset.in_ready", ifA.in_ready, 1'b1);
    step(0, 0, 0, 0, 8'h00, 1);

    // DEPTH=1 throughput: from empty, 10 cycles of offered traffic give 5 pushes.
    pushesB = 0;
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 8'hC3 + 8'(i), 1);
    chk("B.throughput", pushesB, 5);
    repeat (3) step(0, 0, 0, 0, 8'h00, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(7) == 0), ($urandom_range(15) == 0),
           ($urandom_range(3) != 0), 8'($urandom), ($urandom_range(1) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
